// File: rtl/mux_rr_arbiter.sv
// Round-robin owner of a shared 8:1 bit-select mux, with a hold limit under contention
// and a registered, valid-qualified copy of the selected data bit.
module mux_rr_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] din,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       y,
  output logic       y_valid
);

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [2:0] ptr, ptr_nx;
  logic [2:0] sel_nx;
  logic [3:0] hold_cnt, hold_nx;
  logic [7:0] gnt_nx;
  logic       gnt_valid_nx;
  logic [7:0] others;
  logic [3:0] idle_pick, next_pick;

  // Returns {found, index} of the first set bit of r at or above start, wrapping mod 8.
  function automatic logic [3:0] search(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    search = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (r[idx]) search = {1'b1, idx};
    end
  endfunction

  assign others    = req & ~(8'd1 << sel);
  assign idle_pick = search(req, ptr);
  assign next_pick = search(others, sel + 3'd1);

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    sel_nx       = sel;
    hold_nx      = hold_cnt;
    gnt_nx       = gnt;
    gnt_valid_nx = gnt_valid;
    case (state)
      IDLE: begin
        if (req != 8'd0) begin
          sel_nx       = idle_pick[2:0];
          gnt_nx       = 8'd1 << idle_pick[2:0];
          gnt_valid_nx = 1'b1;
          hold_nx      = 4'd1;
          state_nx     = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel]) begin
          ptr_nx = sel + 3'd1;
          if (next_pick[3]) begin
            sel_nx  = next_pick[2:0];
            gnt_nx  = 8'd1 << next_pick[2:0];
            hold_nx = 4'd1;
          end else begin
            gnt_nx       = 8'd0;
            gnt_valid_nx = 1'b0;
            hold_nx      = 4'd0;
            state_nx     = IDLE;
          end
        end else if (hold_cnt == HOLD_LIMIT && others != 8'd0) begin
          // Owner has used up its turn while someone else waits: hand over.
          ptr_nx  = sel + 3'd1;
          sel_nx  = next_pick[2:0];
          gnt_nx  = 8'd1 << next_pick[2:0];
          hold_nx = 4'd1;
        end else if (hold_cnt != HOLD_LIMIT) begin
          hold_nx = hold_cnt + 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= 4'd0;
      sel       <= 3'd0;
      gnt       <= 8'd0;
      gnt_valid <= 1'b0;
      y         <= 1'b0;
      y_valid   <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      hold_cnt  <= hold_nx;
      sel       <= sel_nx;
      gnt       <= gnt_nx;
      gnt_valid <= gnt_valid_nx;
      y         <= gnt_valid ? din[sel] : 1'b0;
      y_valid   <= gnt_valid;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural round-robin model.
module tb_mux_rr_arbiter;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic [7:0] din = 8'd0;
  logic [2:0] sel;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       y;
  logic       y_valid;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state: who owns the mux, where the next search starts, turn length.
  bit m_active = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_hold   = 0;
  bit m_y      = 1'b0;
  bit m_yv     = 1'b0;

  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .sel(sel), .gnt(gnt), .gnt_valid(gnt_valid), .y(y), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [7:0] r, input int start, input int excl);
    for (int off = 0; off < 8; off++) begin
      int k;
      k = (start + off) % 8;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  function automatic logic [13:0] model_vec();
    logic [2:0] s;
    logic [7:0] g;
    s = m_active ? 3'(m_owner) : 3'd0;
    g = m_active ? (8'd1 << m_owner) : 8'd0;
    return {s, g, m_active, m_y, m_yv};
  endfunction

  // sel is only meaningful while a grant is active.
  function automatic logic [13:0] dut_vec();
    return {(gnt_valid ? sel : 3'd0), gnt, gnt_valid, y, y_valid};
  endfunction

  task automatic step(input bit r_in, input logic [7:0] rq, input logic [7:0] d);
    int k;
    rst = r_in;
    req = rq;
    din = d;
    @(posedge clk);
    if (r_in) begin
      m_active = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_y = 0; m_yv = 0;
    end else begin
      m_y  = m_active ? d[m_owner] : 1'b0;
      m_yv = m_active;
      if (!m_active) begin
        if (rq != 8'd0) begin
          m_owner = pick(rq, m_ptr, -1); m_active = 1; m_hold = 1;
        end
      end else if (!rq[m_owner]) begin
        m_ptr = (m_owner + 1) % 8;
        k = pick(rq, m_ptr, m_owner);
        if (k >= 0) begin
          m_owner = k; m_hold = 1;
        end else begin
          m_active = 0; m_hold = 0;
        end
      end else if (m_hold == MAX_HOLD && (rq & ~(8'd1 << m_owner)) != 8'd0) begin
        m_ptr = (m_owner + 1) % 8;
        m_owner = pick(rq, m_ptr, m_owner);
        m_hold = 1;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hFF, 8'hFF);
      vectors++;
      if ({sel, gnt, gnt_valid, y, y_valid} !== 14'd0) begin
        miscompares++;
        $display("[TB] FAIL reset cyc%0d: got sel=%0d gnt=%h gv=%b y=%b yv=%b, want all 0",
                 i, sel, gnt, gnt_valid, y, y_valid);
      end
    end
  endtask

  task automatic test_single();
    logic [13:0] want [4];
    want[0] = {3'd2, 8'h04, 1'b1, 1'b0, 1'b0};
    want[1] = {3'd2, 8'h04, 1'b1, 1'b1, 1'b1};
    want[2] = {3'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    want[3] = {3'd0, 8'h00, 1'b0, 1'b0, 1'b0};
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, (i < 2) ? 8'h04 : 8'h00, 8'h04);
      vectors++;
      if (dut_vec() !== want[i]) begin
        miscompares++;
        $display("[TB] FAIL single cyc%0d: got %b want %b", i, dut_vec(), want[i]);
      end
    end
  endtask

  task automatic test_rr_order();
    logic [7:0] reqs [5];
    logic [7:0] want [5];
    reqs = '{8'h83, 8'h82, 8'h80, 8'h00, 8'hFF};
    want = '{8'h01, 8'h02, 8'h80, 8'h00, 8'h01};
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, reqs[i], 8'($urandom));
      vectors++;
      if (gnt !== want[i] || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL rr_order cyc%0d: got gnt=%h vec=%b want gnt=%h vec=%b",
                 i, gnt, dut_vec(), want[i], model_vec());
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [7:0] want;
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h03, 8'($urandom));
      want = (((i / MAX_HOLD) % 2) == 0) ? 8'h01 : 8'h02;
      vectors++;
      if (gnt !== want || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL hold_limit cyc%0d: got gnt=%h vec=%b want gnt=%h vec=%b",
                 i, gnt, dut_vec(), want, model_vec());
      end
    end
  endtask

  task automatic test_sole_hog();
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h20, 8'($urandom));
      vectors++;
      if (gnt !== 8'h20 || sel !== 3'd5 || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL sole_hog cyc%0d: got gnt=%h sel=%0d vec=%b want gnt=20 sel=5 vec=%b",
                 i, gnt, sel, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] want [4];
    want = '{8'h08, 8'h08, 8'h00, 8'h08};
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step(i == 2, 8'h08, 8'hFF);
      vectors++;
      if (gnt !== want[i] || (i == 2 && dut_vec() !== 14'd0) || dut_vec() !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL mid_reset cyc%0d: got gnt=%h vec=%b want gnt=%h vec=%b",
                 i, gnt, dut_vec(), want[i], model_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] rq;
    rq = 8'd0;
    step(1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 8'($urandom) & 8'($urandom);
      step($urandom_range(0, 63) == 0, rq, 8'($urandom));
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("[TB] FAIL random cyc%0d req=%h: got %b want %b", i, rq, dut_vec(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr_order();
    test_hold_limit();
    test_sole_hog();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
